// File: rtl/bit_serial_sched_pkg.sv
// Shared types and sizes for the bit-serial scheduler: FSM state encoding,
// mask/index/tag widths and the per-beat output bundle.
package bit_serial_sched_pkg;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             zero;
        logic             last;
        logic [IDX_W:0]   beat;
        logic [TAG_W-1:0] tag;
    } beat_t;

endpackage

// File: rtl/lead_one_enc.sv
// MSB-first leading-one encoder: bit 15 maps to index 0, bit 0 to index 15.
// An all-zero input reports index 0 with is_zero set.
module lead_one_enc
    import bit_serial_sched_pkg::*;
(
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             is_zero
);

    // Scan upward so the highest set bit is the one left in idx.
    always_comb begin
        idx     = {IDX_W{1'b0}};
        is_zero = (mask == {WIDTH{1'b0}});
        for (int i = 0; i < WIDTH; i++) begin
            idx = mask[i] ? IDX_W'(WIDTH - 1 - i) : idx;
        end
    end

endmodule

// File: rtl/bit_serial_scheduler.sv
// Turns one essential-bit mask into a stream of leading-one indices, one beat per
// PE handshake. Optional perf counters enabled by macro BIT_SERIAL_SCHED_PERF_EN.
module bit_serial_scheduler
    import bit_serial_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_last,
    output logic [IDX_W:0]   out_beat,
    output logic [TAG_W-1:0] out_tag
`ifdef BIT_SERIAL_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_busy,
    output logic [31:0]      perf_stall
`endif
);

    state_e           state_r, state_n_s;
    logic [WIDTH-1:0] mask_r, mask_n_s;
    logic [TAG_W-1:0] tag_r, tag_n_s;
    logic [IDX_W:0]   beat_r, beat_n_s;
    logic [IDX_W-1:0] lead_idx_s;
    logic             lead_zero_s;
    logic [WIDTH-1:0] cleared_s;
    logic             last_s;
    beat_t            beat_s;

    lead_one_enc u_lead_one_enc (
        .mask    (mask_r),
        .idx     (lead_idx_s),
        .is_zero (lead_zero_s)
    );

    // A zero mask "clears" bit 15, which is already zero, so no special case.
    assign cleared_s = mask_r & ~({1'b1, {(WIDTH-1){1'b0}}} >> lead_idx_s);
    assign last_s    = lead_zero_s | (cleared_s == {WIDTH{1'b0}});

    assign beat_s.idx  = lead_idx_s;
    assign beat_s.zero = lead_zero_s;
    assign beat_s.last = last_s;
    assign beat_s.beat = beat_r;
    assign beat_s.tag  = tag_r;

    assign out_valid = (state_r == RUN);
    assign out_idx   = beat_s.idx;
    assign out_zero  = beat_s.zero;
    assign out_last  = beat_s.last;
    assign out_beat  = beat_s.beat;
    assign out_tag   = beat_s.tag;

    assign in_ready = ~reset & ((state_r == IDLE) | ((state_r == RUN) & out_ready & last_s));

    // Next-state and datapath update for accept, beat advance and retire.
    always_comb begin
        state_n_s = state_r;
        mask_n_s  = mask_r;
        tag_n_s   = tag_r;
        beat_n_s  = beat_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n_s = RUN;
                    mask_n_s  = in_mask;
                    tag_n_s   = in_tag;
                    beat_n_s  = 5'd0;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                if (out_ready & last_s & in_valid) begin
                    state_n_s = RUN;
                    mask_n_s  = in_mask;
                    tag_n_s   = in_tag;
                    beat_n_s  = 5'd0;
                end else if (out_ready & last_s) begin
                    state_n_s = IDLE;
                    mask_n_s  = {WIDTH{1'b0}};
                    tag_n_s   = {TAG_W{1'b0}};
                    beat_n_s  = 5'd0;
                end else if (out_ready) begin
                    mask_n_s  = cleared_s;
                    beat_n_s  = beat_r + 5'd1;
                end else begin
                    state_n_s = RUN;
                end
            end
            default: begin
                state_n_s = IDLE;
                mask_n_s  = {WIDTH{1'b0}};
                tag_n_s   = {TAG_W{1'b0}};
                beat_n_s  = 5'd0;
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mask_r  <= {WIDTH{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
            beat_r  <= 5'd0;
        end else begin
            state_r <= state_n_s;
            mask_r  <= mask_n_s;
            tag_r   <= tag_n_s;
            beat_r  <= beat_n_s;
        end
    end

`ifdef BIT_SERIAL_SCHED_PERF_EN
    logic [31:0] busy_r, stall_r;

    // Saturating occupancy and back-pressure counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 32'd0;
            stall_r <= 32'd0;
        end else begin
            if ((state_r == RUN) && (busy_r != 32'hFFFF_FFFF)) begin
                busy_r <= busy_r + 32'd1;
            end else begin
                busy_r <= busy_r;
            end
            if (out_valid && !out_ready && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign perf_busy  = busy_r;
    assign perf_stall = stall_r;
`endif

endmodule

// File: tb/tb_bit_serial_scheduler.sv
// Bench for bit_serial_scheduler: queue-of-beats reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bit_serial_scheduler;
    import bit_serial_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_mask = 16'h0000;
    logic [7:0]  in_tag = 8'h00;
    logic        in_ready, out_valid, out_zero, out_last;
    logic [3:0]  out_idx;
    logic [4:0]  out_beat;
    logic [7:0]  out_tag;
`ifdef BIT_SERIAL_SCHED_PERF_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    bit_serial_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .out_tag   (out_tag)
`ifdef BIT_SERIAL_SCHED_PERF_EN
        ,
        .perf_busy (perf_busy),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int accepted_cnt = 0;

    typedef struct {
        int idx;
        bit zero;
        bit last;
        int beat;
        int tag;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected beat list: one entry per set bit, highest bit first; zero mask -> one zero beat.
    function automatic void push_mask(input logic [15:0] m, input logic [7:0] t);
        int cnt;
        int n;
        exp_t e;
        cnt = $countones(m);
        n = 0;
        if (m == 16'h0000) begin
            e.idx = 0; e.zero = 1'b1; e.last = 1'b1; e.beat = 0; e.tag = int'(t);
            q.push_back(e);
        end else begin
            for (int b = 15; b >= 0; b--) begin
                if (m[b]) begin
                    e.idx = 15 - b; e.zero = 1'b0; e.last = (n == cnt - 1);
                    e.beat = n; e.tag = int'(t);
                    q.push_back(e);
                    n++;
                end
            end
        end
    endfunction

    function automatic bit exp_ready();
        return !reset && ((q.size() == 0) || ((q.size() == 1) && out_ready));
    endfunction

    // Reference model update on each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
            end else begin
                bit rdy;
                rdy = exp_ready();
                if ((q.size() > 0) && out_ready) void'(q.pop_front());
                if (in_valid && rdy) begin
                    push_mask(in_mask, in_tag);
                    accepted_cnt++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, 32'(q.size() > 0));
            chk("in_ready", in_ready, 32'(exp_ready()));
            if (q.size() > 0) begin
                chk("out_idx", out_idx, q[0].idx);
                chk("out_zero", out_zero, 32'(q[0].zero));
                chk("out_last", out_last, 32'(q[0].last));
                chk("out_beat", out_beat, q[0].beat);
                chk("out_tag", out_tag, q[0].tag);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] m, input logic [7:0] t);
        int tgt;
        int k;
        in_valid = 1'b1;
        in_mask  = m;
        in_tag   = t;
        tgt = accepted_cnt + 1;
        k = 0;
        while ((accepted_cnt < tgt) && (k < 50)) begin
            step();
            k++;
        end
        if (accepted_cnt < tgt) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready", in_ready, 32'd0);
        chk("rst_out_beat", out_beat, 32'd0);
        chk("rst_out_tag", out_tag, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 32'd1);
        step();

        // Two set bits at the extremes.
        send(16'h8001, 8'h11);
        chk("t1_b0_idx", out_idx, 32'd0);
        chk("t1_b0_beat", out_beat, 32'd0);
        chk("t1_b0_last", out_last, 32'd0);
        step();
        chk("t1_b1_idx", out_idx, 32'd15);
        chk("t1_b1_beat", out_beat, 32'd1);
        chk("t1_b1_last", out_last, 32'd1);
        step();
        chk("t1_idle", out_valid, 32'd0);

        // Zero mask still yields one beat.
        send(16'h0000, 8'h5A);
        chk("t2_zero", out_zero, 32'd1);
        chk("t2_idx", out_idx, 32'd0);
        chk("t2_last", out_last, 32'd1);
        chk("t2_tag", out_tag, 32'h5A);
        step();
        chk("t2_idle", out_valid, 32'd0);

        // Full mask: sixteen beats.
        send(16'hFFFF, 8'h33);
        for (int i = 0; i < 16; i++) begin
            chk("t3_idx", out_idx, i);
            chk("t3_last", out_last, 32'(i == 15));
            chk("t3_in_ready", in_ready, 32'(i == 15));
            step();
        end
        chk("t3_idle", out_valid, 32'd0);

        // Back-to-back masks with in_valid held.
        send(16'h0300, 8'h41);
        in_valid = 1'b1;
        in_mask  = 16'h0004;
        in_tag   = 8'h42;
        chk("t4_b0_idx", out_idx, 32'd6);
        step();
        chk("t4_b1_idx", out_idx, 32'd7);
        chk("t4_b1_ready", in_ready, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t4_b2_valid", out_valid, 32'd1);
        chk("t4_b2_idx", out_idx, 32'd13);
        chk("t4_b2_tag", out_tag, 32'h42);
        chk("t4_b2_beat", out_beat, 32'd0);
        step();
        chk("t4_idle", out_valid, 32'd0);

        // Three cycles of back-pressure on beat 0.
        out_ready = 1'b0;
        send(16'h0410, 8'h55);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_idx", out_idx, 32'd5);
            chk("t5_hold_beat", out_beat, 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("t5_rel_idx", out_idx, 32'd5);
        step();
        chk("t5_b1_idx", out_idx, 32'd11);
        chk("t5_b1_last", out_last, 32'd1);
`ifdef BIT_SERIAL_SCHED_PERF_EN
        chk("t5_perf_stall", perf_stall, 32'd3);
`endif
        step();
        chk("t5_idle", out_valid, 32'd0);

        // Reset while beat 1 is on the output.
        send(16'h00F0, 8'h66);
        chk("t6_b0_idx", out_idx, 32'd8);
        step();
        chk("t6_b1_idx", out_idx, 32'd9);
        reset = 1'b1;
        step();
        chk("t6_rst_valid", out_valid, 32'd0);
        chk("t6_rst_ready", in_ready, 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_post_ready", in_ready, 32'd1);
        step();
        chk("t6_post_valid", out_valid, 32'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
